// File: rtl/execute_lsu_pkg.sv
// Shared definitions for the execute-stage load/store unit: access size
// encodings, FSM state encoding and a size-to-byte-count helper.
package execute_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_W = 2'd1;
  localparam logic [1:0] SIZE_D = 2'd2;
  localparam logic [1:0] SIZE_Q = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_B0   = 2'd1,
    LSU_B1   = 2'd2,
    LSU_CAP  = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given size encoding.
  function automatic logic [8:0] size_bytes(input logic [1:0] size);
    logic [8:0] n;
    case (size)
      SIZE_B:  n = 9'd1;
      SIZE_W:  n = 9'd2;
      SIZE_D:  n = 9'd4;
      SIZE_Q:  n = 9'd8;
      default: n = 9'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/execute_lsu_chk.sv
// Simulation checker: flags accepted requests whose size exceeds the
// memory word or the register width.
module execute_lsu_chk import execute_lsu_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 64
) (
  input logic       clk,
  input logic       rst,
  input logic       accept,
  input logic [1:0] req_size
);

  localparam int MAX_BYTES = (DATA_W / 8 < REG_W / 8) ? DATA_W / 8 : REG_W / 8;

  // Check the access size of every accepted request.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      assert (32'(size_bytes(req_size)) <= 32'(MAX_BYTES))
        else $error("execute_lsu: illegal req_size %0d", req_size);
    end
  end

endmodule

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment shared by both memory beats: byte mask over
// two words, store data shifted into lanes, and load extract/extend.
module lsu_lane_align import execute_lsu_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 64,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES),
  localparam int WIDE_W = 2 * DATA_W,
  localparam int IDX_W  = $clog2(WIDE_W)
) (
  input  logic [OFF_W-1:0]   off,
  input  logic [1:0]         size,
  input  logic               sext,
  input  logic [REG_W-1:0]   st_data,
  input  logic [WIDE_W-1:0]  ld_raw,
  output logic [2*BYTES-1:0] mask,
  output logic [DATA_W-1:0]  wdata_lo,
  output logic [DATA_W-1:0]  wdata_hi,
  output logic [REG_W-1:0]   ld_data
);

  logic [8:0]         bytes_n_s;
  logic [2*BYTES-1:0] base_mask_s;
  logic [WIDE_W-1:0]  st_wide_s;
  logic [WIDE_W-1:0]  ld_shift_s;
  logic [IDX_W-1:0]   sign_idx_s;
  logic               sign_s;
  logic               unused_ok_s;

  // Build the mask, lane-shift the store data and extract/extend the load value.
  always_comb begin
    bytes_n_s = size_bytes(size);
    for (int i = 0; i < 2 * BYTES; i++) begin
      base_mask_s[i] = (i < int'(bytes_n_s));
    end
    mask       = base_mask_s << off;
    st_wide_s  = WIDE_W'(st_data) << {off, 3'b000};
    wdata_lo   = st_wide_s[DATA_W-1:0];
    wdata_hi   = st_wide_s[WIDE_W-1:DATA_W];
    ld_shift_s = ld_raw >> {off, 3'b000};
    sign_idx_s = IDX_W'({bytes_n_s, 3'b000} - 12'd1);
    sign_s     = sext & ld_shift_s[sign_idx_s];
    for (int i = 0; i < REG_W; i++) begin
      ld_data[i] = (i < int'({bytes_n_s, 3'b000})) ? ld_shift_s[i] : sign_s;
    end
  end

  // Bits shifted above the register width never reach the result.
  assign unused_ok_s = ^ld_shift_s[WIDE_W-1:REG_W];

endmodule

// File: rtl/execute_lsu.sv
// Execute-stage load/store unit: computes base + displacement, drives the
// word-addressed data memory in one or two beats and returns a registered
// completion with the assembled load result.
module execute_lsu import execute_lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int REG_W  = 64,
  parameter int IMM_W  = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_sext,
  input  logic [REG_W-1:0]    req_base,
  input  logic [IMM_W-1:0]    req_imm,
  input  logic [REG_W-1:0]    req_data,
  input  logic [TAG_W-1:0]    req_tag,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [REG_W-1:0]    rsp_data,
  output logic [TAG_W-1:0]    rsp_tag
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int WORD_W = ADDR_W - OFF_W;

  lsu_state_e          state_r, state_nxt_s;
  logic                accept_s, split_s, unused_ok_s;
  logic [REG_W-1:0]    ea_full_s;
  logic [ADDR_W-1:0]   ea_s;
  logic [OFF_W-1:0]    off_s, off_r, align_off_s;
  logic [WORD_W-1:0]   word_s, word_r;
  logic [1:0]          size_r, align_size_s;
  logic                split_r, store_r, sext_r;
  logic [TAG_W-1:0]    tag_r;
  logic [BYTES-1:0]    we_hi_r;
  logic [DATA_W-1:0]   wdata_hi_r, beat0_r;
  logic [2*BYTES-1:0]  mask_s;
  logic [DATA_W-1:0]   wdata_lo_s, wdata_hi_s;
  logic [2*DATA_W-1:0] ld_raw_s;
  logic [REG_W-1:0]    ld_data_s;
  logic                ready_nxt_s, rsp_valid_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_nxt_s;
  logic [BYTES-1:0]    mem_we_nxt_s;
  logic [DATA_W-1:0]   mem_wdata_nxt_s;
  logic [REG_W-1:0]    rsp_data_nxt_s;
  logic [TAG_W-1:0]    rsp_tag_nxt_s;

  assign accept_s  = req_valid & req_ready;
  assign ea_full_s = req_base + {{(REG_W-IMM_W){req_imm[IMM_W-1]}}, req_imm};
  assign ea_s      = ea_full_s[ADDR_W-1:0];
  assign off_s     = ea_s[OFF_W-1:0];
  assign word_s    = ea_s[ADDR_W-1:OFF_W];
  assign split_s   = ({{(9-OFF_W){1'b0}}, off_s} + size_bytes(req_size)) > 9'(BYTES);
  // Address bits above ADDR_W wrap away.
  assign unused_ok_s = ^ea_full_s[REG_W-1:ADDR_W];

  // The store side works on the incoming request; the load side on the latched one.
  assign align_off_s  = (state_r == LSU_IDLE) ? off_s : off_r;
  assign align_size_s = (state_r == LSU_IDLE) ? req_size : size_r;
  assign ld_raw_s     = split_r ? {mem_rdata, beat0_r} : {{DATA_W{1'b0}}, mem_rdata};

  lsu_lane_align #(.DATA_W(DATA_W), .REG_W(REG_W)) u_align (
    .off      (align_off_s),
    .size     (align_size_s),
    .sext     (sext_r),
    .st_data  (req_data),
    .ld_raw   (ld_raw_s),
    .mask     (mask_s),
    .wdata_lo (wdata_lo_s),
    .wdata_hi (wdata_hi_s),
    .ld_data  (ld_data_s)
  );

  execute_lsu_chk #(.DATA_W(DATA_W), .REG_W(REG_W)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept_s),
    .req_size (req_size)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= LSU_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    case (state_r)
      LSU_IDLE: state_nxt_s = accept_s ? LSU_B0 : LSU_IDLE;
      LSU_B0:   state_nxt_s = split_r ? LSU_B1 : LSU_CAP;
      LSU_B1:   state_nxt_s = LSU_CAP;
      LSU_CAP:  state_nxt_s = LSU_IDLE;
      default:  state_nxt_s = LSU_IDLE;
    endcase
  end

  // Next values of the registered outputs for each state.
  always_comb begin
    ready_nxt_s     = (state_nxt_s == LSU_IDLE);
    mem_addr_nxt_s  = mem_addr;
    mem_we_nxt_s    = {BYTES{1'b0}};
    mem_wdata_nxt_s = mem_wdata;
    rsp_valid_nxt_s = 1'b0;
    rsp_data_nxt_s  = rsp_data;
    rsp_tag_nxt_s   = rsp_tag;
    case (state_r)
      LSU_IDLE: begin
        if (accept_s) begin
          mem_addr_nxt_s  = {{OFF_W{1'b0}}, word_s};
          mem_we_nxt_s    = req_store ? mask_s[BYTES-1:0] : {BYTES{1'b0}};
          mem_wdata_nxt_s = wdata_lo_s;
        end else begin
          mem_we_nxt_s = {BYTES{1'b0}};
        end
      end
      LSU_B0: begin
        if (split_r) begin
          mem_addr_nxt_s  = {{OFF_W{1'b0}}, word_r + {{(WORD_W-1){1'b0}}, 1'b1}};
          mem_we_nxt_s    = we_hi_r;
          mem_wdata_nxt_s = wdata_hi_r;
        end else begin
          mem_we_nxt_s = {BYTES{1'b0}};
        end
      end
      LSU_B1: begin
        mem_we_nxt_s = {BYTES{1'b0}};
      end
      LSU_CAP: begin
        rsp_valid_nxt_s = 1'b1;
        rsp_data_nxt_s  = store_r ? {REG_W{1'b0}} : ld_data_s;
        rsp_tag_nxt_s   = tag_r;
      end
      default: begin
        mem_we_nxt_s = {BYTES{1'b0}};
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_we    <= {BYTES{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_data  <= {REG_W{1'b0}};
      rsp_tag   <= {TAG_W{1'b0}};
    end else begin
      req_ready <= ready_nxt_s;
      mem_addr  <= mem_addr_nxt_s;
      mem_we    <= mem_we_nxt_s;
      mem_wdata <= mem_wdata_nxt_s;
      rsp_valid <= rsp_valid_nxt_s;
      rsp_data  <= rsp_data_nxt_s;
      rsp_tag   <= rsp_tag_nxt_s;
    end
  end

  // Request context latched at accept; first load beat held while beat 1 is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_r      <= {OFF_W{1'b0}};
      size_r     <= 2'd0;
      sext_r     <= 1'b0;
      store_r    <= 1'b0;
      split_r    <= 1'b0;
      word_r     <= {WORD_W{1'b0}};
      tag_r      <= {TAG_W{1'b0}};
      we_hi_r    <= {BYTES{1'b0}};
      wdata_hi_r <= {DATA_W{1'b0}};
      beat0_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      off_r      <= off_s;
      size_r     <= req_size;
      sext_r     <= req_sext;
      store_r    <= req_store;
      split_r    <= split_s;
      word_r     <= word_s;
      tag_r      <= req_tag;
      we_hi_r    <= req_store ? mask_s[2*BYTES-1:BYTES] : {BYTES{1'b0}};
      wdata_hi_r <= wdata_hi_s;
    end else if (state_r == LSU_B1) begin
      beat0_r <= mem_rdata;
    end
  end

endmodule
